ad760x_par_drive: RTL and testbench
===================================

// Module: ad760x_par_drive
// PURPOSE
//  Parametrised parallel-bus driver for the AD7606-family ADC (4/6/8 channels). Issues periodic
//  CONVST, waits on BUSY, reads N words over CS/RD and streams them to the user side as
//  channel-tagged beats with a frame-last flag. Runtime oversampling and sample period;
//  BUSY timeout recovery. Sits between the ADC pins and the capture/FIFO logic.
// PARAMETERS
//  P_CHNL_NUM      8    channels read per frame (4, 6 or 8)
//  P_DATA_W        16   ADC word width
//  P_RST_CYC       10   o_ad_reset high time, clocks
//  P_CONV_LOW_CYC  3    CONVST low pulse width, clocks
//  P_RD_LOW_CYC    2    RD low time per word, clocks
//  P_RD_HIGH_CYC   2    RD high time between words, clocks
//  P_BUSY_TMO_CYC  2000 max clocks waiting for BUSY to fall after CONVST
// PORTS
//  i_clk            in   1         system clock
//  i_rst_n          in   1         async reset, active low
//  i_user_ctrl      in   1         1 = sample continuously; 0 = stop after current frame
//  i_user_os        in   3         oversampling ratio code; latched at each frame start
//  i_user_period    in   16        frame period in clocks, CONVST edge to edge (min 2)
//  o_user_data      out  P_DATA_W  sample word
//  o_user_valid     out  1         one-cycle strobe per word
//  o_user_chnl      out  CHW       channel index, CHW=$clog2(P_CHNL_NUM)
//  o_user_last      out  1         with valid on the final channel of a frame
//  o_busy_tmo       out  1         one-cycle pulse on BUSY timeout
//  o_ad_psb_sel     out  1         tied 0 (parallel)
//  o_ad_stby        out  1         tied 1 (active)
//  o_ad_osc         out  3         OS pins
//  o_ad_reset       out  1         ADC reset
//  o_ad_convstA/B   out  1         conversion start, driven identically
//  o_ad_cs          out  1         chip select, active low
//  o_ad_rd          out  1         read strobe, active low
//  i_ad_busy        in   1         ADC busy (async, 2-FF synchronised)
//  i_ad_firstdata   in   1         FRSTDATA
//  i_ad_data        in   P_DATA_W  parallel data
// BEHAVIOUR
//  Reset: o_ad_reset=1, convst=1, cs=1, rd=1, o_ad_osc=0, all user outputs 0.
//  FSM: RESET -> IDLE -> CONV -> WAIT_BUSY -> READ -> GAP -> (CONV | IDLE).
//  RESET: hold o_ad_reset high P_RST_CYC clocks, then low, go IDLE.
//  IDLE: when i_user_ctrl=1, latch OS into o_ad_osc and period, go CONV.
//  CONV: convst low P_CONV_LOW_CYC clocks, then high; the period counter starts at the falling edge.
//  WAIT_BUSY: wait for rising then falling edge of synchronised BUSY. If no falling edge within
//   P_BUSY_TMO_CYC: pulse o_busy_tmo, drop the frame (no valids), go RESET.
//  READ: cs low for the whole frame; per word RD low P_RD_LOW_CYC, sample i_ad_data on the last
//   low cycle, RD high P_RD_HIGH_CYC; a valid appears 1 clock after the RD rising edge.
//   The channel counter runs 0..P_CHNL_NUM-1; last asserts at P_CHNL_NUM-1; then cs high.
//  GAP: wait until the period counter reaches i_user_period-1. If the read overruns the period,
//   start the next CONV immediately (no error). i_user_ctrl=0 seen in GAP -> IDLE.
//  i_user_ctrl deasserted mid-frame: the frame completes fully, then IDLE.
//  OS/period changes apply only at frame start. Period values 0/1 behave as 2.
//  Async reset mid-READ: abort, all outputs return to reset values in the same cycle.
// CONFIGURATION
//  AD760X_FRSTDATA_CHK_EN defined: adds port o_frame_err (out, 1). The check samples
//   i_ad_firstdata together with each word; it must be 1 at channel 0 and 0 at the others.
//   On a mismatch, pulse o_frame_err with the offending valid and suppress o_user_last for that
//   frame; data is still output.
//  Not defined: i_ad_firstdata is ignored and no o_frame_err port exists.
// STRUCTURE
//  Package ad760x_pkg: FSM state enum, OS code constants, P_* default timing constants.
//  Sub-module ad760x_rd_seq: per-word RD low/high timer + channel counter,
//   start/done handshake with the top FSM.
//  Top holds the main FSM, the period counter, the BUSY synchroniser and the timeout counter.
// TESTING
//  1 Reset release, ctrl=1, BUSY model 40 clk, data=16'h5555 -> reset high 10 clk; 8 valids,
//    chnl 0..7, last on chnl 7, data 5555.
//  2 period=500, OS=3'b010 -> CONVST falling edges exactly 500 clk apart; o_ad_osc=010 from the
//    first CONVST.
//  3 BUSY stuck low after CONVST -> o_busy_tmo at clk 2000; no valids; RESET sequence re-runs.
//  4 ctrl dropped in the middle of READ -> the frame finishes with 8 valids; no further CONVST.
//  5 P_CHNL_NUM=4, period=10 (overrun) -> 4 valids per frame; CONVST back-to-back after GAP.
//  6 FRSTDATA_CHK_EN, FRSTDATA high on chnl 1 -> o_frame_err pulses on chnl 0 and 1; no last
//    on that frame.

Source files
------------

// File: rtl/ad760x_pkg.sv
// Shared types, OS codes and default timing for the AD7606-family parallel-bus driver.
// The optional FRSTDATA check is enabled by defining AD760X_FRSTDATA_CHK_EN.
package ad760x_pkg;

  typedef enum logic [2:0] {
    S_RESET, S_IDLE, S_CONV, S_WAIT_BUSY, S_READ, S_GAP
  } state_t;

  typedef enum logic [1:0] {R_IDLE, R_LOW, R_HIGH} rd_state_t;

  typedef struct packed {
    state_t    top_state;
    rd_state_t rd_state;
  } dbg_t;

  localparam logic [2:0] OS_NONE = 3'b000;
  localparam logic [2:0] OS_X2   = 3'b001;
  localparam logic [2:0] OS_X4   = 3'b010;
  localparam logic [2:0] OS_X8   = 3'b011;
  localparam logic [2:0] OS_X16  = 3'b100;
  localparam logic [2:0] OS_X32  = 3'b101;
  localparam logic [2:0] OS_X64  = 3'b110;

  localparam int DEF_CHNL_NUM     = 8;
  localparam int DEF_DATA_W       = 16;
  localparam int DEF_RST_CYC      = 10;
  localparam int DEF_CONV_LOW_CYC = 3;
  localparam int DEF_RD_LOW_CYC   = 2;
  localparam int DEF_RD_HIGH_CYC  = 2;
  localparam int DEF_BUSY_TMO_CYC = 2000;

  localparam logic [15:0] MIN_PERIOD = 16'd2;

  function automatic logic [15:0] clamp_period(input logic [15:0] p);
    return (p < MIN_PERIOD) ? MIN_PERIOD : p;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ad760x_rd_seq.sv
// Per-word RD strobe timer and channel counter for one ADC frame.
// Handshake: a one-cycle start pulse launches a frame; a one-cycle done pulse follows the last word's RD high time.
module ad760x_rd_seq
  import ad760x_pkg::*;
#(
  parameter  int P_CHNL_NUM    = DEF_CHNL_NUM,
  parameter  int P_DATA_W      = DEF_DATA_W,
  parameter  int P_RD_LOW_CYC  = DEF_RD_LOW_CYC,
  parameter  int P_RD_HIGH_CYC = DEF_RD_HIGH_CYC,
  localparam int CHW           = $clog2(P_CHNL_NUM)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [P_DATA_W-1:0] ad_data,
  input  logic                ad_first,
  output logic                rd,
  output logic [P_DATA_W-1:0] data,
  output logic                valid,
  output logic [CHW-1:0]      chnl,
  output logic                last,
  output logic                first,
  output logic                done,
  output rd_state_t           state
);

  localparam logic [7:0]     LOW_END  = 8'(P_RD_LOW_CYC - 1);
  localparam logic [7:0]     HIGH_END = 8'(P_RD_HIGH_CYC - 1);
  localparam logic [CHW-1:0] LAST_CH  = CHW'(P_CHNL_NUM - 1);

  logic [7:0]     cnt;
  logic [CHW-1:0] ch;
  logic           first_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= R_IDLE;
      cnt     <= '0;
      ch      <= '0;
      first_q <= 1'b0;
      rd      <= 1'b1;
      data    <= '0;
      valid   <= 1'b0;
      chnl    <= '0;
      last    <= 1'b0;
      first   <= 1'b0;
      done    <= 1'b0;
    end else begin
      valid <= 1'b0;
      last  <= 1'b0;
      done  <= 1'b0;
      unique case (state)
        R_IDLE: if (start) begin
          state <= R_LOW;
          rd    <= 1'b0;
          cnt   <= '0;
          ch    <= '0;
        end
        // Capture on the last low cycle, i.e. at the edge that raises RD.
        R_LOW: if (cnt == LOW_END) begin
          rd      <= 1'b1;
          data    <= ad_data;
          first_q <= ad_first;
          cnt     <= '0;
          state   <= R_HIGH;
        end else begin
          cnt <= cnt + 8'd1;
        end
        R_HIGH: begin
          if (cnt == '0) begin
            valid <= 1'b1;
            chnl  <= ch;
            last  <= (ch == LAST_CH);
            first <= first_q;
          end
          if (cnt == HIGH_END) begin
            cnt <= '0;
            if (ch == LAST_CH) begin
              state <= R_IDLE;
              done  <= 1'b1;
            end else begin
              ch    <= ch + 1'b1;
              rd    <= 1'b0;
              state <= R_LOW;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/ad760x_par_drive.sv
// AD7606-family parallel-bus driver: periodic CONVST, BUSY wait with timeout, framed channel read-out.
// Define AD760X_FRSTDATA_CHK_EN to add the FRSTDATA alignment check and the o_frame_err port.
module ad760x_par_drive
  import ad760x_pkg::*;
#(
  parameter  int P_CHNL_NUM     = DEF_CHNL_NUM,
  parameter  int P_DATA_W       = DEF_DATA_W,
  parameter  int P_RST_CYC      = DEF_RST_CYC,
  parameter  int P_CONV_LOW_CYC = DEF_CONV_LOW_CYC,
  parameter  int P_RD_LOW_CYC   = DEF_RD_LOW_CYC,
  parameter  int P_RD_HIGH_CYC  = DEF_RD_HIGH_CYC,
  parameter  int P_BUSY_TMO_CYC = DEF_BUSY_TMO_CYC,
  localparam int CHW            = $clog2(P_CHNL_NUM)
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_user_ctrl,
  input  logic [2:0]          i_user_os,
  input  logic [15:0]         i_user_period,
  output logic [P_DATA_W-1:0] o_user_data,
  output logic                o_user_valid,
  output logic [CHW-1:0]      o_user_chnl,
  output logic                o_user_last,
  output logic                o_busy_tmo,
`ifdef AD760X_FRSTDATA_CHK_EN
  output logic                o_frame_err,
`endif
  output logic                o_ad_psb_sel,
  output logic                o_ad_stby,
  output logic [2:0]          o_ad_osc,
  output logic                o_ad_reset,
  output logic                o_ad_convstA,
  output logic                o_ad_convstB,
  output logic                o_ad_cs,
  output logic                o_ad_rd,
  input  logic                i_ad_busy,
  input  logic                i_ad_firstdata,
  input  logic [P_DATA_W-1:0] i_ad_data,
  output dbg_t                o_dbg
);

  localparam int            CW       = $clog2(max3(P_BUSY_TMO_CYC, P_RST_CYC, P_CONV_LOW_CYC) + 1);
  localparam logic [CW-1:0] RST_END  = CW'(P_RST_CYC - 1);
  localparam logic [CW-1:0] CONV_END = CW'(P_CONV_LOW_CYC - 1);
  localparam logic [CW-1:0] TMO_END  = CW'(P_BUSY_TMO_CYC - 1);

  state_t      state;
  rd_state_t   seq_state;
  logic [CW-1:0] cnt;
  logic [15:0] per_cnt;
  logic [15:0] period_q;
  logic        convst;
  logic        busy_s1, busy_s2, busy_d, seen_rise;
  logic        busy_rise, busy_fall;
  logic        seq_start, seq_done, seq_last, seq_first, seq_valid;
  logic [CHW-1:0] seq_chnl;

  assign busy_rise    = busy_s2 & ~busy_d;
  assign busy_fall    = ~busy_s2 & busy_d;
  assign o_ad_psb_sel = 1'b0;
  assign o_ad_stby    = 1'b1;
  assign o_ad_convstA = convst;
  assign o_ad_convstB = convst;
  assign o_user_valid = seq_valid;
  assign o_user_chnl  = seq_chnl;
  assign o_dbg        = '{top_state: state, rd_state: seq_state};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_s1 <= 1'b0;
      busy_s2 <= 1'b0;
      busy_d  <= 1'b0;
    end else begin
      busy_s1 <= i_ad_busy;
      busy_s2 <= busy_s1;
      busy_d  <= busy_s2;
    end
  end

  // per_cnt restarts at every CONVST falling edge and saturates so long overruns never wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_RESET;
      cnt        <= '0;
      per_cnt    <= '0;
      period_q   <= MIN_PERIOD;
      convst     <= 1'b1;
      o_ad_cs    <= 1'b1;
      o_ad_osc   <= OS_NONE;
      o_ad_reset <= 1'b1;
      o_busy_tmo <= 1'b0;
      seen_rise  <= 1'b0;
      seq_start  <= 1'b0;
    end else begin
      seq_start  <= 1'b0;
      o_busy_tmo <= 1'b0;
      if (per_cnt != 16'hFFFF) per_cnt <= per_cnt + 16'd1;
      if (busy_rise) seen_rise <= 1'b1;
      unique case (state)
        S_RESET: if (cnt == RST_END) begin
          o_ad_reset <= 1'b0;
          cnt        <= '0;
          state      <= S_IDLE;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_IDLE: if (i_user_ctrl) begin
          state     <= S_CONV;
          convst    <= 1'b0;
          cnt       <= '0;
          per_cnt   <= '0;
          seen_rise <= 1'b0;
          o_ad_osc  <= i_user_os;
          period_q  <= clamp_period(i_user_period);
        end
        S_CONV: if (cnt == CONV_END) begin
          convst <= 1'b1;
          cnt    <= '0;
          state  <= S_WAIT_BUSY;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_WAIT_BUSY: if (busy_fall && seen_rise) begin
          o_ad_cs   <= 1'b0;
          seq_start <= 1'b1;
          state     <= S_READ;
        end else if (cnt == TMO_END) begin
          o_busy_tmo <= 1'b1;
          o_ad_reset <= 1'b1;
          cnt        <= '0;
          state      <= S_RESET;
        end else begin
          cnt <= cnt + 1'b1;
        end
        S_READ: if (seq_done) begin
          o_ad_cs <= 1'b1;
          state   <= S_GAP;
        end
        S_GAP: if (!i_user_ctrl) begin
          state <= S_IDLE;
        end else if (per_cnt >= period_q - 16'd1) begin
          state     <= S_CONV;
          convst    <= 1'b0;
          cnt       <= '0;
          per_cnt   <= '0;
          seen_rise <= 1'b0;
          o_ad_osc  <= i_user_os;
          period_q  <= clamp_period(i_user_period);
        end
        default: state <= S_RESET;
      endcase
    end
  end

  ad760x_rd_seq #(
    .P_CHNL_NUM    (P_CHNL_NUM),
    .P_DATA_W      (P_DATA_W),
    .P_RD_LOW_CYC  (P_RD_LOW_CYC),
    .P_RD_HIGH_CYC (P_RD_HIGH_CYC)
  ) u_rd_seq (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .start    (seq_start),
    .ad_data  (i_ad_data),
    .ad_first (i_ad_firstdata),
    .rd       (o_ad_rd),
    .data     (o_user_data),
    .valid    (seq_valid),
    .chnl     (seq_chnl),
    .last     (seq_last),
    .first    (seq_first),
    .done     (seq_done),
    .state    (seq_state)
  );

`ifdef AD760X_FRSTDATA_CHK_EN
  logic err_now, err_seen;
  // FRSTDATA must be high exactly on channel 0; any miss spoils the frame's last flag.
  assign err_now     = seq_valid & (seq_first != (seq_chnl == '0));
  assign o_frame_err = err_now;
  assign o_user_last = seq_last & ~(err_now | err_seen);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       err_seen <= 1'b0;
    else if (seq_start) err_seen <= 1'b0;
    else if (err_now)   err_seen <= 1'b1;
  end
`else
  logic unused_first;
  assign unused_first = seq_first;
  assign o_user_last  = seq_last;
`endif

endmodule

// File: tb/tb_ad760x_par_drive.sv
// Directed bench for ad760x_par_drive: 8-channel instance A and 4-channel instance B sharing one ADC model.
// Define AD760X_FRSTDATA_CHK_EN to include the FRSTDATA check scenario.
module tb_ad760x_par_drive;
  import ad760x_pkg::*;

  localparam int DW = 16;
  localparam int NA = 8;
  localparam int NB = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // stimulus and DUT wiring
  logic ctrl_a = 1'b0, ctrl_b = 1'b0;
  logic [2:0] os = 3'b000;
  logic [15:0] period = 16'd500;
  logic ad_busy = 1'b0, ad_first = 1'b0;
  logic [DW-1:0] ad_data = '0;

  logic [DW-1:0] data_a, data_b;
  logic valid_a, last_a, tmo_a, psb_a, stby_a, reset_a, cva_a, cvb_a, cs_a, rd_a;
  logic valid_b, last_b, tmo_b, psb_b, stby_b, reset_b, cva_b, cvb_b, cs_b, rd_b;
  logic [2:0] osc_a, osc_b, chnl_a;
  logic [1:0] chnl_b;
  dbg_t dbg_a, dbg_b;
`ifdef AD760X_FRSTDATA_CHK_EN
  logic err_a, err_b;
`endif

  ad760x_par_drive #(.P_CHNL_NUM(NA)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_user_ctrl(ctrl_a), .i_user_os(os), .i_user_period(period),
    .o_user_data(data_a), .o_user_valid(valid_a), .o_user_chnl(chnl_a), .o_user_last(last_a),
    .o_busy_tmo(tmo_a),
`ifdef AD760X_FRSTDATA_CHK_EN
    .o_frame_err(err_a),
`endif
    .o_ad_psb_sel(psb_a), .o_ad_stby(stby_a), .o_ad_osc(osc_a), .o_ad_reset(reset_a),
    .o_ad_convstA(cva_a), .o_ad_convstB(cvb_a), .o_ad_cs(cs_a), .o_ad_rd(rd_a),
    .i_ad_busy(ad_busy), .i_ad_firstdata(ad_first), .i_ad_data(ad_data), .o_dbg(dbg_a)
  );

  ad760x_par_drive #(.P_CHNL_NUM(NB)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_user_ctrl(ctrl_b), .i_user_os(os), .i_user_period(period),
    .o_user_data(data_b), .o_user_valid(valid_b), .o_user_chnl(chnl_b), .o_user_last(last_b),
    .o_busy_tmo(tmo_b),
`ifdef AD760X_FRSTDATA_CHK_EN
    .o_frame_err(err_b),
`endif
    .o_ad_psb_sel(psb_b), .o_ad_stby(stby_b), .o_ad_osc(osc_b), .o_ad_reset(reset_b),
    .o_ad_convstA(cva_b), .o_ad_convstB(cvb_b), .o_ad_cs(cs_b), .o_ad_rd(rd_b),
    .i_ad_busy(ad_busy), .i_ad_firstdata(ad_first), .i_ad_data(ad_data), .o_dbg(dbg_b)
  );

  // ADC model: BUSY high 40 clocks after a CONVST rising edge; word k = base + k when data_inc
  wire conv_any = cva_a & cva_b;
  wire rd_any   = rd_a & rd_b;
  wire cs_any   = cs_a & cs_b;
  logic busy_stuck = 1'b0;
  logic data_inc = 1'b0;
  logic [DW-1:0] data_base = '0;
  int frst_ch = 0;
  int rd_idx = 0;

  initial forever begin
    @(posedge conv_any);
    if (!busy_stuck && rst_n) begin
      @(posedge clk);
      ad_busy = 1'b1;
      repeat (40) @(posedge clk);
      ad_busy = 1'b0;
    end
  end

  initial forever begin
    @(negedge cs_any);
    rd_idx = 0;
  end

  initial forever begin
    @(negedge rd_any);
    ad_data  = data_base + (data_inc ? DW'(rd_idx) : DW'(0));
    ad_first = (rd_idx == frst_ch);
    rd_idx++;
  end

  // scoreboard
  logic [DW-1:0] exp_q_a[$];
  logic [DW-1:0] exp_q_b[$];
  int exp_ch_a = 0, exp_ch_b = 0, vcnt_a = 0, vcnt_b = 0;
  logic bad_frame_a = 1'b0;
  int falls_a = 0, falls_b = 0, fall_cyc_a = 0, fall_cyc_b = 0, cs_rise_cyc_b = 0;
  logic cv_a_d = 1'b1, cv_b_d = 1'b1, cs_b_d = 1'b1;

  always @(negedge clk) begin
    if (valid_a) begin
      check("a_q_nonempty", exp_q_a.size() != 0, 1);
      if (exp_q_a.size() != 0) check("a_data", data_a, exp_q_a.pop_front());
      check("a_chnl", chnl_a, exp_ch_a);
      check("a_last", last_a, (exp_ch_a == NA - 1) && !bad_frame_a);
`ifdef AD760X_FRSTDATA_CHK_EN
      check("a_frame_err", err_a, (exp_ch_a == 0) != (exp_ch_a == frst_ch));
`endif
      exp_ch_a = (exp_ch_a == NA - 1) ? 0 : exp_ch_a + 1;
      vcnt_a++;
    end
    if (valid_b) begin
      check("b_q_nonempty", exp_q_b.size() != 0, 1);
      if (exp_q_b.size() != 0) check("b_data", data_b, exp_q_b.pop_front());
      check("b_chnl", chnl_b, exp_ch_b);
      check("b_last", last_b, exp_ch_b == NB - 1);
      exp_ch_b = (exp_ch_b == NB - 1) ? 0 : exp_ch_b + 1;
      vcnt_b++;
    end
    if (cv_a_d && !cva_a) begin
      falls_a++;
      fall_cyc_a = cyc;
      check("a_convstB_low", cvb_a, 0);
    end
    if (cv_b_d && !cva_b) begin
      falls_b++;
      fall_cyc_b = cyc;
    end
    if (!cs_b_d && cs_b) cs_rise_cyc_b = cyc;
    cv_a_d = cva_a;
    cv_b_d = cva_b;
    cs_b_d = cs_b;
  end

  // driver tasks
  task automatic wait_falls(input bit sel_b, input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (((sel_b ? falls_b : falls_a) < n) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, (sel_b ? falls_b : falls_a) >= n, 1);
  endtask

  task automatic wait_drain(input bit sel_b, input int budget, input string tag);
    int k;
    k = 0;
    while (((sel_b ? exp_q_b.size() : exp_q_a.size()) != 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, sel_b ? exp_q_b.size() : exp_q_a.size(), 0);
  endtask

  task automatic count_reset_high(output int n);
    n = 0;
    while (reset_a && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  int n, c0, k0;

  initial begin
    period = 16'd500;
    os = 3'b010;
    data_base = 16'h5555;
    data_inc = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ad_reset", reset_a, 1);
    check("rst_convst", cva_a, 1);
    check("rst_cs", cs_a, 1);
    check("rst_rd", rd_a, 1);
    check("rst_osc", osc_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_data", data_a, 0);
    check("rst_tmo", tmo_a, 0);
    check("tie_psb", psb_a, 0);
    check("tie_stby", stby_a, 1);

    // 1: reset pulse length, one constant-data frame
    ctrl_a = 1'b1;
    for (int i = 0; i < NA; i++) exp_q_a.push_back(16'h5555);
    rst_n = 1'b1;
    count_reset_high(n);
    check("t1_reset_len", n, 10);
    wait_falls(0, 1, 50, "t1_conv1");
    c0 = fall_cyc_a;
    check("t2_osc_first", osc_a, 3'b010);
    wait_drain(0, 300, "t1_drain");
    check("t1_vcnt", vcnt_a, 8);

    // 2: period 500, OS latched only at frame start
    os = 3'b101;
    data_base = 16'h1230;
    data_inc = 1'b1;
    check("t2_osc_hold", osc_a, 3'b010);
    for (int i = 0; i < NA; i++) exp_q_a.push_back(16'h1230 + 16'(i));
    wait_falls(0, 2, 600, "t2_conv2");
    check("t2_period", fall_cyc_a - c0, 500);
    check("t2_osc_new", osc_a, 3'b101);

    // 4: ctrl dropped mid-READ
    n = 0;
    while (vcnt_a < 11 && n < 300) begin
      @(negedge clk);
      n++;
    end
    ctrl_a = 1'b0;
    wait_drain(0, 200, "t4_drain");
    repeat (600) @(negedge clk);
    check("t4_vcnt", vcnt_a, 16);
    check("t4_no_conv", falls_a, 2);
    check("t4_cs_idle", cs_a, 1);
    check("t4_state", dbg_a.top_state, S_IDLE);

    // 3: BUSY stuck low -> timeout and reset re-run
    busy_stuck = 1'b1;
    ctrl_a = 1'b1;
    n = 0;
    while (cva_a && n < 50) begin @(posedge clk); #1; n++; end
    while (!cva_a && n < 50) begin @(posedge clk); #1; n++; end
    check("t3_conv_seen", n < 50, 1);
    n = 0;
    while (!tmo_a && n < 3000) begin @(posedge clk); #1; n++; end
    check("t3_tmo_cyc", n, 2000);
    ctrl_a = 1'b0;
    check("t3_reset_rerun", reset_a, 1);
    @(posedge clk); #1;
    check("t3_tmo_pulse", tmo_a, 0);
    count_reset_high(n);
    check("t3_reset_len", n, 9);
    check("t3_no_valid", vcnt_a, 16);
    busy_stuck = 1'b0;
    repeat (5) @(negedge clk);

    // 5: 4-channel instance, period 10 overrun
    period = 16'd10;
    data_base = 16'hC000;
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < NB; i++) exp_q_b.push_back(16'hC000 + 16'(i));
    ctrl_b = 1'b1;
    wait_falls(1, 1, 50, "t5_conv1");
    wait_falls(1, 2, 300, "t5_conv2");
    ctrl_b = 1'b0;
    check("t5_gap", fall_cyc_b - cs_rise_cyc_b, 1);
    wait_drain(1, 300, "t5_drain");
    repeat (20) @(negedge clk);
    check("t5_vcnt", vcnt_b, 8);
    check("t5_falls", falls_b, 2);

    // async reset in the middle of READ
    period = 16'd500;
    data_base = 16'h0A00;
    for (int i = 0; i < NA; i++) exp_q_a.push_back(16'h0A00 + 16'(i));
    ctrl_a = 1'b1;
    n = 0;
    while (vcnt_a < 18 && n < 300) begin @(negedge clk); n++; end
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("rr_cs", cs_a, 1);
    check("rr_rd", rd_a, 1);
    check("rr_reset", reset_a, 1);
    check("rr_convst", cva_a, 1);
    check("rr_valid", valid_a, 0);
    check("rr_osc", osc_a, 0);
    check("rr_data", data_a, 0);
    ctrl_a = 1'b0;
    exp_q_a.delete();
    exp_ch_a = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check("rr_state", dbg_a.top_state, S_IDLE);

`ifdef AD760X_FRSTDATA_CHK_EN
    // 6: FRSTDATA on channel 1 instead of 0
    frst_ch = 1;
    bad_frame_a = 1'b1;
    data_base = 16'h7700;
    for (int i = 0; i < NA; i++) exp_q_a.push_back(16'h7700 + 16'(i));
    k0 = falls_a;
    ctrl_a = 1'b1;
    wait_falls(0, k0 + 1, 50, "t6_conv");
    ctrl_a = 1'b0;
    wait_drain(0, 300, "t6_drain");
    repeat (10) @(negedge clk);
    frst_ch = 0;
    bad_frame_a = 1'b0;
`endif

    check("end_q_a", exp_q_a.size(), 0);
    check("end_q_b", exp_q_b.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
